counter_sched: RTL and testbench

- Round-robin scheduler that shares one WIDTH-bit up-counter between NREQ requesters.
- Each requester asks for a timed run of len+1 counting cycles. The scheduler grants one requester at a time, loads and sequences the counter, and pulses a per-requester done.
- Sits between client blocks and the counter datapath; the counter itself is an internal sub-module.

---
 rtl/counter_sched_pkg.sv | 18 +
 rtl/counter_sched_count_core.sv | 42 ++++
 rtl/counter_sched.sv | 160 ++++++++++++++++
 tb/tb_counter_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sched_pkg.sv
// rtl/counter_sched_pkg.sv - shared types and defaults for the counter scheduler
//
// Purpose: FSM state encoding and default parameter values used by
//          counter_sched and its bench.
// Ports:   none (package)
package counter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEFAULT_NREQ  = 4;
  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/counter_sched_count_core.sv
// rtl/counter_sched_count_core.sv - WIDTH-bit up-counter shared by all requesters
//
// Purpose: synchronous clear / count-enable counter; clear wins over enable.
// Ports:
//   clk   in   rising-edge clock
//   reset in   asynchronous active-high reset
//   clr   in   clear to zero on next edge
//   en    in   increment on next edge
//   out   out  current count
module count_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out = cnt_q;

endmodule

// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - round-robin scheduler sharing one up-counter among NREQ requesters
//
// Purpose: arbitrates req in IDLE (round robin from rr pointer), then runs the
//          shared counter from 0 to the winner's latched len and pulses done.
// Optional: COUNTER_SCHED_ABORT_EN adds the abort input, which ends a LOAD/RUN
//          phase early with out held and a normal done pulse.
// Ports:
//   clk   in   rising-edge clock
//   reset in   asynchronous active-high reset
//   req   in   NREQ request bits, sampled only in IDLE
//   len   in   NREQ*WIDTH packed terminal counts, requester i at [i*WIDTH +: WIDTH]
//   gnt   out  one-hot grant, held through LOAD and RUN
//   busy  out  high whenever the FSM is not in IDLE
//   done  out  one-cycle completion pulse for the granted requester
//   out   out  current counter value
//   abort in   (COUNTER_SCHED_ABORT_EN only) terminate the active run
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NREQ  = DEFAULT_NREQ,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      out
`ifdef COUNTER_SCHED_ABORT_EN
  ,
  input  logic                  abort
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q;
  logic [IW-1:0]     winner_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     ptr_d;
  logic [WIDTH-1:0]  len_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;

  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     cand_idx;
  logic [WIDTH-1:0]  pick_len;
  int                cand;

  logic              abort_w;
  logic              at_end;
  logic              cnt_clr;
  logic              cnt_en;

`ifdef COUNTER_SCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first set req bit at or above ptr_q, wrapping at NREQ
  // (NREQ need not be a power of two, so the wrap is explicit).
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cand_idx = IW'(cand);
      if (!pick_found && req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign pick_len = len[int'(pick_idx)*WIDTH +: WIDTH];
  assign ptr_d    = (winner_q == IW'(NREQ - 1)) ? '0 : winner_q + 1'b1;

  // Terminal compare is taken before the increment, so len_q = all-ones
  // stops at all-ones instead of wrapping.
  assign at_end  = (out == len_q);
  assign cnt_clr = (state_q == LOAD) && !abort_w;
  assign cnt_en  = (state_q == RUN) && !at_end && !abort_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      winner_q <= '0;
      ptr_q    <= '0;
      len_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            winner_q <= pick_idx;
            len_q    <= pick_len;
            gnt_q    <= onehot(pick_idx);
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          if (abort_w) begin
            gnt_q   <= '0;
            done_q  <= onehot(winner_q);
            state_q <= DONE;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (at_end || abort_w) begin
            gnt_q   <= '0;
            done_q  <= onehot(winner_q);
            state_q <= DONE;
          end
        end
        DONE: begin
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  count_core #(
    .WIDTH(WIDTH)
  ) u_count_core (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .out  (out)
  );

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_counter_sched.sv
// tb/tb_counter_sched.sv - scoreboard bench for counter_sched
module tb_counter_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] len = '0;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      out;
`ifdef COUNTER_SCHED_ABORT_EN
  logic                  abort = 1'b0;
`endif

  int tests  = 0;
  int failed = 0;

  // One entry per run expected to complete: winner index, counter value
  // shown with done, and number of cycles gnt was held (LOAD + RUN cycles).
  typedef struct {
    int idx;
    int fout;
    int gcyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   run_cycles = 0;

  counter_sched #(
    .NREQ (NREQ),
    .WIDTH(WIDTH)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .req  (req),
    .len  (len),
    .gnt  (gnt),
    .busy (busy),
    .done (done),
    .out  (out)
`ifdef COUNTER_SCHED_ABORT_EN
    ,
    .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_len(input int i, input int v);
    len[i*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic push_exp(input int idx, input int fout, input int gcyc);
    exp_t x;
    x.idx  = idx;
    x.fout = fout;
    x.gcyc = gcyc;
    sb.push_back(x);
  endtask

  // Holds reset across two falling edges so the monitor always observes it,
  // and checks the reset values while it is held.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("reset_gnt", int'(gnt), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_out", int'(out), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: per-cycle sanity plus scoreboard pop on every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      run_cycles = 0;
    end else begin
      check("gnt_onehot", int'($countones(gnt) <= 1), 1);
      check("busy_state", int'(busy), int'((gnt != 0) || (done != 0)));
      if (gnt != 0) begin
        run_cycles++;
        if (run_cycles >= 2) begin
          check("run_out_step", int'(out), run_cycles - 2);
        end
      end
      if (done != 0) begin
        if (sb.size() == 0) begin
          check("done_unexpected", int'(done), 0);
        end else begin
          e = sb.pop_front();
          check("done_who", int'(done), 1 << e.idx);
          check("done_out", int'(out), e.fout);
          check("gnt_cycles", run_cycles, e.gcyc);
        end
        run_cycles = 0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] rv;
    int              lv[NREQ];
    int              n;
    int              seen;
    int              budget;
    int              model_ptr;
    int              w;
    int              c;

    // Single requester, len=3: exact cycle-by-cycle timing.
    do_reset();
    len = '0;
    set_len(0, 3);
    push_exp(0, 3, 5);
    req = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("t1_gnt_c1", int'(gnt), 1);
        req = '0;
      end
      if (k >= 2 && k <= 5) check("t1_out", int'(out), k - 2);
      check("t1_done", int'(done), (k == 6) ? 1 : 0);
      if (k == 7) check("t1_busy_c7", int'(busy), 0);
    end

    // All requesting with len=0: grants rotate 0,1,2,3,0, one every 4 cycles.
    do_reset();
    len = '0;
    for (int j = 0; j < 5; j++) push_exp(j % NREQ, 0, 2);
    req = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if ((k - 1) % 4 == 0) check("t2_gnt_order", int'(gnt), 1 << (((k - 1) / 4) % NREQ));
      if ((k - 1) % 4 == 3) check("t2_idle_gap", int'(busy), 0);
      if (k == 17) req = '0;
    end

    // Full-range length: out tops out at 15 and does not wrap.
    do_reset();
    len = '0;
    set_len(0, 15);
    push_exp(0, 15, 17);
    req = 4'b0001;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 1) req = '0;
      if (k == 17) check("t3_out_max", int'(out), 15);
      if (k == 18) begin
        check("t3_done_c18", int'(done), 1);
        check("t3_out_held", int'(out), 15);
      end
      if (k == 19) check("t3_busy_c19", int'(busy), 0);
    end

    // req dropped and len changed mid-run: latched len=5 still completes.
    set_len(0, 5);
    push_exp(0, 5, 7);
    req = 4'b0001;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 3) begin
        req = '0;
        set_len(0, 1);
      end
      if (k == 7) check("t4_no_early_done", int'(done), 0);
      if (k == 8) check("t4_done_c8", int'(done), 1);
      if (k == 9) check("t4_busy_c9", int'(busy), 0);
    end

    // Asynchronous reset mid-run at out=2: immediate clear, no done.
    len = '0;
    set_len(2, 6);
    req = 4'b0100;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) check("t5_gnt_c1", int'(gnt), 4);
      if (k == 4) check("t5_out_before", int'(out), 2);
    end
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_gnt", int'(gnt), 0);
    check("t5_async_busy", int'(busy), 0);
    check("t5_async_out", int'(out), 0);
    check("t5_async_done", int'(done), 0);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    len = '0;
    push_exp(0, 0, 2);
    req = 4'b1111;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("t5_restart_gnt", int'(gnt), 1);
        req = '0;
      end
    end

`ifdef COUNTER_SCHED_ABORT_EN
    // Abort during RUN at out=4: out held, done next cycle, then IDLE.
    do_reset();
    len = '0;
    set_len(0, 10);
    push_exp(0, 4, 6);
    req = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req = '0;
      if (k == 6) begin
        check("t6_out_at_abort", int'(out), 4);
        abort = 1'b1;
      end
      if (k == 7) begin
        check("t6_done", int'(done), 1);
        check("t6_out_held", int'(out), 4);
        abort = 1'b0;
      end
      if (k == 8) check("t6_idle", int'(busy), 0);
    end
    abort = 1'b1;
    @(negedge clk);
    check("t6_abort_idle_ignored", int'(busy), 0);
    abort = 1'b0;
`endif

    // Randomized batches: req/len held for n runs; the model predicts the
    // round-robin winner sequence from its own pointer.
    do_reset();
    model_ptr = 0;
    for (int b = 0; b < 25; b++) begin
      rv = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        lv[i] = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 5));
        set_len(i, lv[i]);
      end
      n = $urandom_range(1, 6);
      for (int r = 0; r < n; r++) begin
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
          c = (model_ptr + k) % NREQ;
          if (w < 0 && rv[c]) w = c;
        end
        push_exp(w, lv[w], lv[w] + 2);
        model_ptr = (w + 1) % NREQ;
      end
      req    = rv;
      seen   = 0;
      budget = 0;
      while (seen < n && budget < 2000) begin
        @(negedge clk);
        budget++;
        if (done != 0) seen++;
        if (seen == n) req = '0;
      end
      if (seen < n) check("rand_timeout", seen, n);
      req = '0;
      repeat (3) @(negedge clk);
      check("rand_idle", int'(busy), 0);
    end

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
